// File: rtl/calc_program_loader_if.sv
// Host byte stream into the program loader: valid/ready, one byte per accepted beat.
interface calc_program_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/calc_program_loader.sv
// Loads a framed program into the core's memory, releases the core and captures its result;
// memory writes land 1 cycle after each accepted byte; s_ready is low outside IDLE/LOAD.
module calc_program_loader #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int HALT_PC = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    calc_program_loader_if.slave host,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [7:0]           mem_wdata_o,
    output logic                 core_rstn_o,
    input  logic [7:0]           core_pc_i,
    input  logic [7:0]           core_data_i,
    input  logic                 core_exc_i,
    output logic [7:0]           result_o,
    output logic                 result_exc_o,
    output logic                 result_valid_o,
    input  logic                 result_ack_i,
    output logic                 busy_o,
    output logic                 error_o,
    output logic [1:0]           err_code_o
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef struct packed {
        logic [7:0] data;
        logic       exc;
    } result_t;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic              csum_ok_q, csum_ok_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              core_rstn_q, core_rstn_d;
    result_t           res_q, res_d;
    logic              res_vld_q, res_vld_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic byte_acc;
    logic len_bad;
    logic halt_seen;
    logic timeout_hit;

    assign host.s_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy_o       = (state_q != S_IDLE);

    assign byte_acc    = host.s_valid && host.s_ready;
    assign len_bad     = (host.s_data == 8'd0) || (host.s_data > 8'(DEPTH));
    assign halt_seen   = (core_pc_i == 8'(HALT_PC));
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        csum_ok_d   = csum_ok_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rstn_d = core_rstn_q;
        res_d       = res_q;
        res_vld_d   = res_vld_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (byte_acc) begin
                    if (len_bad) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = S_LOAD;
                        len_d   = LEN_W'(host.s_data);
                        idx_d   = '0;
                        sum_d   = 8'd0;
                    end
                end
            end

            S_LOAD: begin
                if (byte_acc) begin
                    if (idx_q < len_q) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q[ADDR_W-1:0];
                        mem_wdata_d = host.s_data;
                        idx_d       = idx_q + LEN_W'(1);
                        sum_d       = sum_q + host.s_data;
                    end else begin
                        // All program bytes are in; this byte is the checksum.
                        csum_ok_d = (host.s_data == sum_q);
                        state_d   = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                if (csum_ok_q) begin
                    state_d     = S_RUN;
                    core_rstn_d = 1'b1;
                    cnt_d       = 8'd0;
                end else begin
                    state_d    = S_ERROR;
                    error_d    = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end

            S_RUN: begin
                // Halt is checked first so it wins a same-cycle timeout.
                if (halt_seen) begin
                    state_d     = S_DONE;
                    core_rstn_d = 1'b0;
                    res_d.data  = core_data_i;
                    res_d.exc   = core_exc_i;
                    res_vld_d   = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = S_ERROR;
                    core_rstn_d = 1'b0;
                    error_d     = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                if (result_ack_i) begin
                    state_d   = S_IDLE;
                    res_vld_d = 1'b0;
                end
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            csum_ok_q   <= 1'b0;
            cnt_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            core_rstn_q <= 1'b0;
            res_q       <= '0;
            res_vld_q   <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            csum_ok_q   <= csum_ok_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rstn_q <= core_rstn_d;
            res_q       <= res_d;
            res_vld_q   <= res_vld_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign core_rstn_o    = core_rstn_q;
    assign result_o       = res_q.data;
    assign result_exc_o   = res_q.exc;
    assign result_valid_o = res_vld_q;
    assign error_o        = error_q;
    assign err_code_o     = err_code_q;
endmodule

// File: tb/tb_calc_program_loader.sv
// Bench for calc_program_loader: randomized frames against a frame-level model and a cycle-counting core model.
module tb_calc_program_loader;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int HALT_PC = 10;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_program_loader_if hif();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rstn;
    logic [7:0]        core_pc;
    logic [7:0]        core_data;
    logic              core_exc;
    logic [7:0]        result;
    logic              result_exc;
    logic              result_valid;
    logic              result_ack;
    logic              busy;
    logic              error;
    logic [1:0]        err_code;

    calc_program_loader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_PC(HALT_PC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .host(hif),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .core_rstn_o(core_rstn), .core_pc_i(core_pc), .core_data_i(core_data), .core_exc_i(core_exc),
        .result_o(result), .result_exc_o(result_exc), .result_valid_o(result_valid),
        .result_ack_i(result_ack), .busy_o(busy), .error_o(error), .err_code_o(err_code)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Core model: counts cycles out of reset; pc follows the count, or parks at 3 and jumps to HALT_PC at halt_at.
    int         run_cnt = 0;
    int         halt_at = -1;
    logic [7:0] run_val = 8'h00;
    logic       run_exc = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_rstn !== 1'b1) run_cnt <= 0;
        else                    run_cnt <= run_cnt + 1;
    end
    assign core_pc   = (halt_at < 0) ? 8'(run_cnt) : ((run_cnt == halt_at) ? 8'(HALT_PC) : 8'd3);
    assign core_data = (core_pc == 8'(HALT_PC)) ? run_val : ~run_val;
    assign core_exc  = (core_pc == 8'(HALT_PC)) ? run_exc : ~run_exc;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    logic [7:0] prog [0:31];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hif.s_valid = 1'b0;
        hif.s_data  = 8'h00;
        result_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    // Offers one byte after a random idle gap; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited;
        waited = 0;
        hif.s_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) tick();
        hif.s_valid = 1'b1;
        hif.s_data  = b;
        while (hif.s_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (hif.s_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_byte: s_ready=%b required 1", hif.s_ready);
        end else begin
            tick();
        end
        hif.s_valid = 1'b0;
        hif.s_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] len_b, input int n, input logic [7:0] ck, input int gap);
        send_byte(len_b, gap);
        for (int i = 0; i < n; i++) send_byte(prog[i], gap);
        send_byte(ck, gap);
    endtask

    function automatic logic [7:0] prog_sum(input int n);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < n; i++) s = s + prog[i];
        return s;
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem: we=%b addr=%h data=%h required 0/0/00", mem_we, mem_addr, mem_wdata); end
        total++; if (core_rstn !== 1'b0) begin bad++; $display("FAIL reset_core_rstn: got %b required 0", core_rstn); end
        total++; if (result !== 8'h00 || result_exc !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL reset_result: %h/%b/%b required 00/0/0", result, result_exc, result_valid); end
        total++; if (error !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL reset_error: %b/%0d required 0/0", error, err_code); end
        total++; if (busy !== 1'b0 || hif.s_ready !== 1'b1) begin bad++; $display("FAIL reset_busy_ready: busy=%b ready=%b required 0/1", busy, hif.s_ready); end
    endtask

    task automatic test_good_load();
        do_reset();
        halt_at = -1;
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03;
        send_frame(8'h03, 3, 8'h06, 0);
        total++; if (core_rstn !== 1'b0 || hif.s_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL load_verify_cycle: rstn=%b ready=%b busy=%b required 0/0/1", core_rstn, hif.s_ready, busy); end
        total++; if (wr_addr_q.size() != 3) begin bad++; $display("FAIL load_write_count: got %0d required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            total++; if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== prog[i]) begin bad++; $display("FAIL load_write[%0d]: %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], i, prog[i]); end
        end
        tick();
        total++; if (core_rstn !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL load_release: rstn=%b error=%b required 1/0", core_rstn, error); end
    endtask

    task automatic test_normal_run();
        int r, n;
        do_reset();
        halt_at = -1; run_val = 8'h36; run_exc = 1'b0;
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03;
        send_frame(8'h03, 3, 8'h06, 2);
        tick();
        r = cyc; n = 0;
        while (result_valid !== 1'b1 && n < 100) begin tick(); n++; end
        total++; if (result_valid !== 1'b1 || cyc - r != HALT_PC + 1) begin bad++; $display("FAIL run_halt_latency: valid=%b cycles=%0d required 1/%0d", result_valid, cyc - r, HALT_PC + 1); end
        total++; if (result !== 8'h36 || result_exc !== 1'b0 || core_rstn !== 1'b0) begin bad++; $display("FAIL run_capture: %h/%b rstn=%b required 36/0/0", result, result_exc, core_rstn); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (result_valid !== 1'b1 || result !== 8'h36 || busy !== 1'b1) begin bad++; $display("FAIL run_hold[%0d]: valid=%b result=%h busy=%b required 1/36/1", i, result_valid, result, busy); end
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        total++; if (result_valid !== 1'b0 || busy !== 1'b0 || hif.s_ready !== 1'b1) begin bad++; $display("FAIL run_ack_clear: valid=%b busy=%b ready=%b required 0/0/1", result_valid, busy, hif.s_ready); end
    endtask

    task automatic test_exception_run();
        int n, len;
        do_reset();
        halt_at = -1; run_val = 8'($urandom); run_exc = 1'b1;
        len = $urandom_range(DEPTH, 1);
        for (int i = 0; i < len; i++) prog[i] = 8'($urandom);
        send_frame(8'(len), len, prog_sum(len), 1);
        n = 0;
        while (result_valid !== 1'b1 && n < 100) begin tick(); n++; end
        total++; if (result_valid !== 1'b1 || result !== run_val || result_exc !== 1'b1) begin bad++; $display("FAIL exc_capture: valid=%b %h/%b required 1/%h/1", result_valid, result, result_exc, run_val); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03;
        send_frame(8'h03, 3, 8'h07, 0);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL csum_verify_cycle: error=%b required 0", error); end
        hif.s_valid = 1'b1;
        result_ack  = 1'b1;
        tick();
        total++; if (error !== 1'b1 || err_code !== 2'd2 || core_rstn !== 1'b0) begin bad++; $display("FAIL csum_error: %b/%0d rstn=%b required 1/2/0", error, err_code, core_rstn); end
        repeat (10) tick();
        total++; if (error !== 1'b1 || err_code !== 2'd2 || hif.s_ready !== 1'b0 || core_rstn !== 1'b0) begin bad++; $display("FAIL csum_sticky: %b/%0d ready=%b rstn=%b required 1/2/0/0", error, err_code, hif.s_ready, core_rstn); end
        hif.s_valid = 1'b0;
        result_ack  = 1'b0;
    endtask

    task automatic test_bad_length();
        logic [7:0] lb;
        do_reset();
        send_byte(8'h00, 0);
        total++; if (error !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL len_zero: %b/%0d required 1/1", error, err_code); end
        for (int k = 0; k < 2; k++) begin
            lb = (k == 0) ? 8'd17 : 8'($urandom_range(255, 17));
            do_reset();
            send_byte(lb, 1);
            hif.s_valid = 1'b1;
            repeat (5) tick();
            hif.s_valid = 1'b0;
            total++; if (err_code !== 2'd1 || wr_addr_q.size() != 0) begin bad++; $display("FAIL len_over[%0d]: code=%0d writes=%0d required 1/0", lb, err_code, wr_addr_q.size()); end
        end
    endtask

    task automatic test_timeout();
        int r, n;
        do_reset();
        halt_at = 100000;
        prog[0] = 8'($urandom); prog[1] = 8'($urandom);
        send_frame(8'h02, 2, prog_sum(2), 1);
        tick();
        r = cyc; n = 0;
        while (error !== 1'b1 && n < 400) begin
            total++; if (core_rstn !== 1'b1) begin bad++; $display("FAIL timeout_rstn_early: rstn=%b at run cycle %0d required 1", core_rstn, cyc - r); end
            tick(); n++;
        end
        total++; if (error !== 1'b1 || err_code !== 2'd3 || cyc - r != TIMEOUT) begin bad++; $display("FAIL timeout_entry: %b/%0d after %0d required 1/3/%0d", error, err_code, cyc - r, TIMEOUT); end
        total++; if (core_rstn !== 1'b0) begin bad++; $display("FAIL timeout_rstn: got %b required 0", core_rstn); end
        halt_at = -1;
    endtask

    task automatic test_halt_timeout_race();
        int r, n;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            halt_at = TIMEOUT - 1 - k;
            run_val = 8'($urandom); run_exc = 1'b0;
            prog[0] = 8'($urandom);
            send_frame(8'h01, 1, prog[0], 0);
            tick();
            r = cyc; n = 0;
            while (result_valid !== 1'b1 && error !== 1'b1 && n < 400) begin tick(); n++; end
            total++; if (result_valid !== 1'b1 || error !== 1'b0 || result !== run_val || cyc - r != halt_at + 1) begin bad++; $display("FAIL race[%0d]: valid=%b error=%b result=%h after %0d required 1/0/%h/%0d", k, result_valid, error, result, cyc - r, run_val, halt_at + 1); end
        end
        halt_at = -1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        prog[0] = 8'($urandom); prog[1] = 8'($urandom);
        send_byte(8'h03, 3);
        send_byte(prog[0], 3);
        send_byte(prog[1], 3);
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || hif.s_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00) begin bad++; $display("FAIL midload_reset: busy=%b ready=%b we=%b addr=%h data=%h required 0/1/0/0/00", busy, hif.s_ready, mem_we, mem_addr, mem_wdata); end
        rst = 1'b0;
        clear_log();
        halt_at = 100000;
        prog[0] = 8'h05; prog[1] = 8'hFB;
        send_frame(8'h02, 2, 8'h00, 3);
        total++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 8'h05 || wr_addr_q[1] !== 4'd1 || wr_data_q[1] !== 8'hFB) begin bad++; $display("FAIL reload_writes: count=%0d required 2 writes 0:05 1:FB", wr_addr_q.size()); end
        tick();
        total++; if (core_rstn !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL reload_run: rstn=%b error=%b required 1/0", core_rstn, error); end
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (core_rstn !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL midrun_reset: rstn=%b busy=%b valid=%b error=%b required 0/0/0/0", core_rstn, busy, result_valid, error); end
        halt_at = -1;
    endtask

    // Frame-level model: length rule, then checksum rule, then the written image and captured result.
    task automatic test_random_frames();
        int len, n;
        logic badck;
        logic [1:0] exp_code;
        logic [7:0] ck;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            halt_at = -1;
            len   = (it == 0) ? DEPTH : (it == 1) ? 1 : $urandom_range(20, 0);
            badck = (it > 1) && ($urandom_range(2, 0) == 0);
            for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
            ck = prog_sum((len <= DEPTH) ? len : 0) + (badck ? 8'($urandom_range(255, 1)) : 8'h00);
            exp_code = (len == 0 || len > DEPTH) ? 2'd1 : (badck ? 2'd2 : 2'd0);
            run_val = 8'($urandom); run_exc = 1'($urandom);
            if (exp_code == 2'd1) send_byte(8'(len), 2);
            else                  send_frame(8'(len), len, ck, 2);
            tick();
            total++; if (error !== (exp_code != 2'd0) || err_code !== exp_code) begin bad++; $display("FAIL rand[%0d] len=%0d: error=%b code=%0d required %b/%0d", it, len, error, err_code, exp_code != 2'd0, exp_code); end
            total++; if (wr_addr_q.size() != ((exp_code == 2'd1) ? 0 : len)) begin bad++; $display("FAIL rand[%0d] write_count: got %0d required %0d", it, wr_addr_q.size(), len); end
            for (int i = 0; i < wr_addr_q.size() && i < len; i++) begin
                total++; if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== prog[i]) begin bad++; $display("FAIL rand[%0d] write[%0d]: %h/%h required %h/%h", it, i, wr_addr_q[i], wr_data_q[i], i, prog[i]); end
            end
            if (exp_code == 2'd0) begin
                n = 0;
                while (result_valid !== 1'b1 && n < 100) begin tick(); n++; end
                total++; if (result_valid !== 1'b1 || result !== run_val || result_exc !== run_exc) begin bad++; $display("FAIL rand[%0d] result: %b %h/%b required 1 %h/%b", it, result_valid, result, result_exc, run_val, run_exc); end
                result_ack = 1'b1;
                tick();
                result_ack = 1'b0;
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        hif.s_valid = 1'b0;
        hif.s_data  = 8'h00;
        result_ack  = 1'b0;
        test_reset();
        test_good_load();
        test_normal_run();
        test_exception_run();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_halt_timeout_race();
        test_reset_mid();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
